// File: rtl/coord_bcd.sv
// Sequential binary-to-BCD converter for the cursor X/Y coordinates.
// Two double-dabble engines run in lockstep, one bit per clock, and the last result is held.
module coord_bcd #(
    parameter int WIDTH  = 11,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      x_in,
    input  logic [WIDTH-1:0]      y_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   x_bcd,
    output logic [4*DIGITS-1:0]   y_bcd,
    output logic                  x_ovf,
    output logic                  y_ovf
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [31:0] MAX = 32'(10 ** DIGITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] x_bin, y_bin;
    logic [BW-1:0]    x_acc, y_acc;
    logic             x_pend, y_pend;

    logic [BW-1:0]    x_adj, y_adj;
    logic [WIDTH-1:0] x_cap, y_cap;
    logic             x_big, y_big;

    // Per-nibble add-3 correction; nibbles never carry into each other.
    function automatic logic [BW-1:0] add3(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_comb begin
        x_adj = add3(x_acc);
        y_adj = add3(y_acc);
        x_big = 32'(x_in) > MAX;
        y_big = 32'(y_in) > MAX;
        x_cap = x_big ? MAX[WIDTH-1:0] : x_in;
        y_cap = y_big ? MAX[WIDTH-1:0] : y_in;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            x_bin  <= '0;
            y_bin  <= '0;
            x_acc  <= '0;
            y_acc  <= '0;
            x_pend <= 1'b0;
            y_pend <= 1'b0;
            x_bcd  <= '0;
            y_bcd  <= '0;
            x_ovf  <= 1'b0;
            y_ovf  <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_bin  <= x_cap;
                        y_bin  <= y_cap;
                        x_pend <= x_big;
                        y_pend <= y_big;
                        x_acc  <= '0;
                        y_acc  <= '0;
                        cnt    <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    // The clamp keeps the value within DIGITS nibbles, so the dropped MSB is always zero.
                    x_acc <= BW'({x_adj, x_bin[WIDTH-1]});
                    y_acc <= BW'({y_adj, y_bin[WIDTH-1]});
                    x_bin <= x_bin << 1;
                    y_bin <= y_bin << 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1))
                        state <= LOAD;
                end
                LOAD: begin
                    x_bcd <= x_acc;
                    y_bcd <= y_acc;
                    x_ovf <= x_pend;
                    y_ovf <= y_pend;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coord_bcd.sv
// Self-checking bench for coord_bcd: vector table, full 0..999 sweep, random values
// against a decimal-arithmetic model, and hand-written multi-cycle sequences.
module tb_coord_bcd;

    localparam int WIDTH  = 11;
    localparam int DIGITS = 3;
    localparam int TOP    = 999;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] x_in, y_in;
    logic        busy, done;
    logic [11:0] x_bcd, y_bcd;
    logic        x_ovf, y_ovf;

    int tests = 0;
    int fails = 0;

    coord_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .x_in  (x_in),
        .y_in  (y_in),
        .busy  (busy),
        .done  (done),
        .x_bcd (x_bcd),
        .y_bcd (y_bcd),
        .x_ovf (x_ovf),
        .y_ovf (y_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          x;
        int          y;
        logic [11:0] ex;
        logic [11:0] ey;
        logic        exo;
        logic        eyo;
    } vec_t;

    // Decimal model: clamp, then split into hundreds/tens/ones with plain division.
    function automatic logic [11:0] ref_bcd(input int v);
        int c;
        c = (v > TOP) ? TOP : v;
        return {4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One start pulse, then observe 14 cycles: busy count, done count and the cycle done appears.
    task automatic applyStimulus(input int x, input int y,
                                 output int done_at, output int done_cnt, output int busy_cnt);
        @(negedge clk);
        x_in  = 11'(x);
        y_in  = 11'(y);
        start = 1'b1;
        done_at  = -1;
        done_cnt = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
        end
    endtask

    task automatic runCheck(input string tag, input int x, input int y,
                            input logic [11:0] ex, input logic [11:0] ey,
                            input logic exo, input logic eyo, input bit timing);
        int da, dc, bc;
        applyStimulus(x, y, da, dc, bc);
        checkOutput({tag, " x_bcd"}, 32'(x_bcd), 32'(ex));
        checkOutput({tag, " y_bcd"}, 32'(y_bcd), 32'(ey));
        checkOutput({tag, " x_ovf"}, 32'(x_ovf), 32'(exo));
        checkOutput({tag, " y_ovf"}, 32'(y_ovf), 32'(eyo));
        if (timing) begin
            checkOutput({tag, " done_cycle"}, 32'(da), 32'(WIDTH + 2));
            checkOutput({tag, " done_count"}, 32'(dc), 32'd1);
            checkOutput({tag, " busy_cycles"}, 32'(bc), 32'(WIDTH + 1));
        end
    endtask

    vec_t vecs[$];
    int   hist_x[0:79];
    int   hist_y[0:79];

    initial begin
        int da, dc, bc, last_done, n_done, rx, ry;

        vecs.push_back('{639,  479,  12'h639, 12'h479, 1'b0, 1'b0});
        vecs.push_back('{0,    1,    12'h000, 12'h001, 1'b0, 1'b0});
        vecs.push_back('{2047, 1000, 12'h999, 12'h999, 1'b1, 1'b1});
        vecs.push_back('{5,    3,    12'h005, 12'h003, 1'b0, 1'b0});
        vecs.push_back('{999,  998,  12'h999, 12'h998, 1'b0, 1'b0});
        vecs.push_back('{500,  1024, 12'h500, 12'h999, 1'b0, 1'b1});

        reset = 1'b0;
        start = 1'b0;
        x_in  = '0;
        y_in  = '0;
        #12;
        checkOutput("reset busy",  32'(busy),  32'd0);
        checkOutput("reset done",  32'(done),  32'd0);
        checkOutput("reset x_bcd", 32'(x_bcd), 32'd0);
        checkOutput("reset y_bcd", 32'(y_bcd), 32'd0);
        checkOutput("reset x_ovf", 32'(x_ovf), 32'd0);
        checkOutput("reset y_ovf", 32'(y_ovf), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i])
            runCheck($sformatf("vec%0d", i), vecs[i].x, vecs[i].y,
                     vecs[i].ex, vecs[i].ey, vecs[i].exo, vecs[i].eyo, 1'b1);

        for (int v = 0; v <= TOP; v++)
            runCheck($sformatf("sweep%0d", v), v, TOP - v, ref_bcd(v), ref_bcd(TOP - v),
                     1'b0, 1'b0, v < 3);

        for (int r = 0; r < 40; r++) begin
            rx = int'($urandom_range(0, 2047));
            ry = int'($urandom_range(0, 2047));
            runCheck($sformatf("rand%0d", r), rx, ry, ref_bcd(rx), ref_bcd(ry),
                     rx > TOP, ry > TOP, 1'b0);
        end

        // Second start while busy must be ignored; mid-flight input changes must not matter.
        @(negedge clk);
        x_in  = 11'd100;
        y_in  = 11'd7;
        start = 1'b1;
        dc = 0;
        da = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start = (k == 3);
            if (k == 3) x_in = 11'd200;
            if (k == 6) x_in = 11'd777;
            if (done) begin
                dc++;
                if (da < 0) da = k;
            end
        end
        checkOutput("ignore done_count", 32'(dc), 32'd1);
        checkOutput("ignore done_cycle", 32'(da), 32'(WIDTH + 2));
        checkOutput("ignore x_bcd", 32'(x_bcd), 32'h100);
        checkOutput("ignore y_bcd", 32'(y_bcd), 32'h007);

        // Asynchronous reset in the middle of a conversion.
        @(negedge clk);
        x_in  = 11'd123;
        y_in  = 11'd456;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("abort busy",  32'(busy),  32'd0);
        checkOutput("abort done",  32'(done),  32'd0);
        checkOutput("abort x_bcd", 32'(x_bcd), 32'd0);
        checkOutput("abort y_bcd", 32'(y_bcd), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        dc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) dc++;
        end
        checkOutput("abort no_done", 32'(dc), 32'd0);
        runCheck("after_abort", 45, 0, 12'h045, 12'h000, 1'b0, 1'b0, 1'b1);

        // Start held high: back-to-back conversions, each using its own capture-edge inputs.
        @(negedge clk);
        hist_x[0] = int'($urandom_range(0, 2047));
        hist_y[0] = int'($urandom_range(0, 2047));
        x_in  = 11'(hist_x[0]);
        y_in  = 11'(hist_y[0]);
        start = 1'b1;
        last_done = 0;
        n_done = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (k >= 13) begin
                    checkOutput($sformatf("stream x_bcd@%0d", k), 32'(x_bcd), 32'(ref_bcd(hist_x[k-13])));
                    checkOutput($sformatf("stream y_bcd@%0d", k), 32'(y_bcd), 32'(ref_bcd(hist_y[k-13])));
                    checkOutput($sformatf("stream x_ovf@%0d", k), 32'(x_ovf), 32'(hist_x[k-13] > TOP));
                    checkOutput($sformatf("stream y_ovf@%0d", k), 32'(y_ovf), 32'(hist_y[k-13] > TOP));
                end
                checkOutput($sformatf("stream spacing@%0d", k), 32'(k - last_done), 32'(WIDTH + 2));
                last_done = k;
            end
            hist_x[k] = int'($urandom_range(0, 2047));
            hist_y[k] = int'($urandom_range(0, 2047));
            x_in = 11'(hist_x[k]);
            y_in = 11'(hist_y[k]);
        end
        start = 1'b0;
        checkOutput("stream done_count", 32'(n_done), 32'd4);
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
